rv_imm_gen_pipe: RTL and testbench
==================================

Name: rv_imm_gen_pipe

Overview:
Registered, handshaked immediate generator for the decode stage. It decodes a fetched instruction word into a sign- or zero-extended XLEN immediate, including all RV32C compressed formats. It sits between the fetch/align buffer and the decode register file read, and adds one pipeline stage with valid/ready backpressure and flush.

Parameters:
XLEN, 32, immediate output width; 32 or 64; extension always fills to XLEN.
EN_RVC, 1, 1 = decode compressed formats when IR[1:0]!=2'b11; 0 = always decode as 32-bit.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
flush  input  1  synchronous pipeline kill.
in_valid  input  1  IR is valid this cycle.
in_ready  output  1  stage can accept IR this cycle.
IR  input  32  instruction word; compressed instruction in IR[15:0], IR[31:16] ignored.
out_valid  output  1  imm/imm_type/is_compressed/c_illegal valid.
out_ready  input  1  consumer accepts the output this cycle.
imm  output  XLEN  generated immediate.
imm_type  output  3  0=I, 1=S, 2=B, 3=U, 4=J, 5=C (compressed).
is_compressed  output  1  instruction was decoded as 16-bit.
c_illegal  output  1  compressed word is reserved/illegal (0x0000, or c.addi4spn with nzuimm=0).

Behaviour:
- Reset: out_valid=0, imm=0, imm_type=0, is_compressed=0, c_illegal=0. in_ready=1 in the first cycle after reset.
- Handshake: in_ready = ~out_valid | out_ready (combinational). Input accepted when in_valid & in_ready. Latency is one cycle: an accepted IR appears on the outputs at the next edge.
- Hold: while out_valid & ~out_ready, all outputs stay bit-stable.
- Simultaneous pop and accept: outputs are replaced and out_valid stays 1. A pop with no accept clears out_valid.
- Flush: out_valid=0 at the next edge. An input accepted in the same cycle is dropped. Data regs may keep stale values.
- rst has priority over flush; flush has priority over accept.
- 32-bit formats (opcode = IR[6:2]); sext = replicate IR[31] to XLEN:
  - I (00100, 00000 load, 11001 JALR, all other opcodes): sext(IR[31:20]).
  - S (01000): sext({IR[31:25],IR[11:7]}).
  - B (11000): sext({IR[31],IR[7],IR[30:25],IR[11:8],0}).
  - U (01101 LUI, 00101 AUIPC): sext({IR[31:12],12'b0}).
  - J (11011): sext({IR[31],IR[19:12],IR[20],IR[30:21],0}).
- Compressed formats (EN_RVC=1 and IR[1:0]!=11; c = IR[15:0], f3 = c[15:13]; zext/sext to XLEN):
  - Q0 f3=000 addi4spn: zext({c[10:7],c[12:11],c[5],c[6],00}).
  - Q0 f3=010/110 lw/sw: zext({c[5],c[12:10],c[6],00}).
  - Q1 f3=000/010 addi/li: sext({c[12],c[6:2]}).
  - Q1 f3=001/101 jal/j: sext({c[12],c[8],c[10:9],c[6],c[7],c[2],c[11],c[5:3],0}).
  - Q1 f3=011, rd=2 (addi16sp): sext({c[12],c[4:3],c[5],c[2],c[6],0000}).
  - Q1 f3=011, rd!=2 (lui): sext({c[12],c[6:2],12'b0}).
  - Q1 f3=100: c[11:10]=00/01 → zext({c[12],c[6:2]}); =10 → sext({c[12],c[6:2]}); =11 → 0.
  - Q1 f3=110/111 beqz/bnez: sext({c[12],c[6:5],c[2],c[11:10],c[4:3],0}).
  - Q2 f3=000 slli: zext({c[12],c[6:2]}).
  - Q2 f3=010 lwsp: zext({c[3:2],c[12],c[6:4],00}).
  - Q2 f3=110 swsp: zext({c[8:7],c[12:9],00}).
  - All other Q0/Q2 encodings: imm=0.
  - All compressed results: imm_type=5, is_compressed=1.
- EN_RVC=0: IR[1:0]!=11 is decoded by the 32-bit table; is_compressed=0, c_illegal=0.

Test Plan:
- Reset, then IR=0xFFF00093 (addi x1,x0,-1), out_ready=1 → next cycle out_valid=1, imm=0xFFFFFFFF, imm_type=0.
- IR=0xFE000EE3 (beq x0,x0,-4) → imm=0xFFFFFFFC, imm_type=2. IR=0xDEAD4432 (c.lwsp x8,12(sp)) → imm=0x0000000C, is_compressed=1, imm_type=5.
- IR=0x0000BFFD (c.j -2) → imm=0xFFFFFFFE. IR=0x00000000 → c_illegal=1. Same words with EN_RVC=0 → is_compressed=0, c_illegal=0.
- Backpressure: out_ready=0, feed A then B → in_ready=0 while A is held and outputs stay stable. Raise out_ready → A pops, B is accepted the same cycle and appears next cycle; no loss or duplication.
- Flush with in_valid=1 and out_valid=1 → out_valid=0 next cycle, input dropped. rst asserted mid-stream with flush and in_valid → all outputs return to reset values.
- XLEN=64: IR=0x800000B7 (lui x1,0x80000) → imm=0xFFFFFFFF80000000. c.lui 0x7085 (x1, imm 0x21→sign -31) → imm=0xFFFFFFFFFFFE1000.

Source files
------------

// File: rtl/rv_imm_gen_pipe.sv
// Decode-stage immediate generator: one registered stage with valid/ready backpressure and flush.
// Handles the RV32I base formats plus all RV32C compressed immediate layouts.
module rv_imm_gen_pipe #(
  parameter int XLEN   = 32,
  parameter int EN_RVC = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     IR,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      imm_type,
  output logic            is_compressed,
  output logic            c_illegal
);

  localparam logic [2:0] T_I = 3'd0;
  localparam logic [2:0] T_S = 3'd1;
  localparam logic [2:0] T_B = 3'd2;
  localparam logic [2:0] T_U = 3'd3;
  localparam logic [2:0] T_J = 3'd4;
  localparam logic [2:0] T_C = 3'd5;

  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  logic [4:0]  opcode;
  logic [15:0] c;
  logic [2:0]  f3;
  logic        use_c;
  logic        accept;

  logic [31:0] w_imm;
  logic [2:0]  w_type;
  logic [31:0] c_imm;
  logic        c_ill;
  logic [31:0] d_imm;
  logic [2:0]  d_type;
  logic        d_comp;
  logic        d_ill;

  assign opcode = IR[6:2];
  assign c      = IR[15:0];
  assign f3     = c[15:13];
  assign use_c  = (EN_RVC != 0) && (IR[1:0] != 2'b11);

  // 32-bit formats; every opcode not listed falls back to the I layout
  always_comb begin
    w_imm  = 32'($signed(IR[31:20]));
    w_type = T_I;
    case (opcode)
      OP_STORE: begin
        w_imm  = 32'($signed({IR[31:25], IR[11:7]}));
        w_type = T_S;
      end
      OP_BRANCH: begin
        w_imm  = 32'($signed({IR[31], IR[7], IR[30:25], IR[11:8], 1'b0}));
        w_type = T_B;
      end
      OP_LUI, OP_AUIPC: begin
        w_imm  = {IR[31:12], 12'b0};
        w_type = T_U;
      end
      OP_JAL: begin
        w_imm  = 32'($signed({IR[31], IR[19:12], IR[20], IR[30:21], 1'b0}));
        w_type = T_J;
      end
      default: ;
    endcase
  end

  // Compressed formats, indexed by quadrant then funct3
  always_comb begin
    c_imm = '0;
    c_ill = 1'b0;
    case (c[1:0])
      2'b00: begin
        case (f3)
          3'b000: begin
            c_imm = 32'({c[10:7], c[12:11], c[5], c[6], 2'b00});
            c_ill = (c[12:5] == 8'd0);
          end
          3'b010, 3'b110: c_imm = 32'({c[5], c[12:10], c[6], 2'b00});
          default: c_imm = '0;
        endcase
      end
      2'b01: begin
        case (f3)
          3'b000, 3'b010: c_imm = 32'($signed({c[12], c[6:2]}));
          3'b001, 3'b101:
            c_imm = 32'($signed({c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0}));
          3'b011: begin
            if (c[11:7] == 5'd2)
              c_imm = 32'($signed({c[12], c[4:3], c[5], c[2], c[6], 4'b0000}));
            else
              c_imm = 32'($signed({c[12], c[6:2], 12'b0}));
          end
          3'b100: begin
            case (c[11:10])
              2'b00, 2'b01: c_imm = 32'({c[12], c[6:2]});
              2'b10:        c_imm = 32'($signed({c[12], c[6:2]}));
              default:      c_imm = '0;
            endcase
          end
          default: c_imm = 32'($signed({c[12], c[6:5], c[2], c[11:10], c[4:3], 1'b0}));
        endcase
      end
      2'b10: begin
        case (f3)
          3'b000:  c_imm = 32'({c[12], c[6:2]});
          3'b010:  c_imm = 32'({c[3:2], c[12], c[6:4], 2'b00});
          3'b110:  c_imm = 32'({c[8:7], c[12:9], 2'b00});
          default: c_imm = '0;
        endcase
      end
      default: c_imm = '0;
    endcase
  end

  always_comb begin
    d_imm  = w_imm;
    d_type = w_type;
    d_comp = 1'b0;
    d_ill  = 1'b0;
    if (use_c) begin
      d_imm  = c_imm;
      d_type = T_C;
      d_comp = 1'b1;
      d_ill  = c_ill;
    end
  end

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  // Decoded values are already extended to 32 bits, so widening by bit 31 is exact
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      imm           <= '0;
      imm_type      <= T_I;
      is_compressed <= 1'b0;
      c_illegal     <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      imm           <= XLEN'($signed(d_imm));
      imm_type      <= d_type;
      is_compressed <= d_comp;
      c_illegal     <= d_ill;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rv_imm_gen_pipe.sv
// Scoreboard bench for rv_imm_gen_pipe: three instances (RV32+C, RV32 no C, RV64+C) share
// clock, IR, flush and out_ready; each has its own in_valid and expectation queue.
module tb_rv_imm_gen_pipe;

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  typ;
    logic        comp;
    logic        ill;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        out_ready;
  logic [31:0] ir;
  logic [2:0]  in_valid_v;
  logic [2:0]  rdy;
  logic [2:0]  ov;
  logic [2:0]  comp_v;
  logic [2:0]  ill_v;
  logic [2:0]  typ_v [3];
  logic [31:0] imm_a;
  logic [31:0] imm_b;
  logic [63:0] imm_c;
  logic [63:0] imm_v [3];

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  int n_pass  = 0;
  int n_total = 0;

  assign imm_v[0] = {32'b0, imm_a};
  assign imm_v[1] = {32'b0, imm_b};
  assign imm_v[2] = imm_c;

  rv_imm_gen_pipe #(.XLEN(32), .EN_RVC(1)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid_v[0]), .in_ready(rdy[0]),
    .IR(ir), .out_valid(ov[0]), .out_ready(out_ready), .imm(imm_a), .imm_type(typ_v[0]),
    .is_compressed(comp_v[0]), .c_illegal(ill_v[0])
  );

  rv_imm_gen_pipe #(.XLEN(32), .EN_RVC(0)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid_v[1]), .in_ready(rdy[1]),
    .IR(ir), .out_valid(ov[1]), .out_ready(out_ready), .imm(imm_b), .imm_type(typ_v[1]),
    .is_compressed(comp_v[1]), .c_illegal(ill_v[1])
  );

  rv_imm_gen_pipe #(.XLEN(64), .EN_RVC(1)) u_c (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid_v[2]), .in_ready(rdy[2]),
    .IR(ir), .out_valid(ov[2]), .out_ready(out_ready), .imm(imm_c), .imm_type(typ_v[2]),
    .is_compressed(comp_v[2]), .c_illegal(ill_v[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  function automatic exp_t mk(input logic [63:0] i, input logic [2:0] t, input logic cp,
                              input logic il);
    exp_t e;
    e.imm  = i;
    e.typ  = t;
    e.comp = cp;
    e.ill  = il;
    return e;
  endfunction

  function automatic int q_size(input int idx);
    case (idx)
      0:       return q_a.size();
      1:       return q_b.size();
      default: return q_c.size();
    endcase
  endfunction

  function automatic exp_t pop_q(input int idx);
    case (idx)
      0:       return q_a.pop_front();
      1:       return q_b.pop_front();
      default: return q_c.pop_front();
    endcase
  endfunction

  // Monitor: every output handshake seen at the falling edge consumes one expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (ov[i] === 1'b1 && out_ready === 1'b1) begin
        if (q_size(i) == 0) begin
          n_total++;
          $display("FAIL unexpected_out[%0d]: got imm %h with no expected entry", i, imm_v[i]);
        end else begin
          e = pop_q(i);
          chk($sformatf("imm[%0d]", i), imm_v[i], e.imm);
          chk($sformatf("imm_type[%0d]", i), 64'(typ_v[i]), 64'(e.typ));
          chk($sformatf("flags[%0d]", i), 64'({comp_v[i], ill_v[i]}), 64'({e.comp, e.ill}));
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the word
  task automatic issue(input logic [2:0] sel, input logic [31:0] word,
                       input exp_t ea, input exp_t eb, input exp_t ec);
    bit done;
    done       = 1'b0;
    ir         = word;
    in_valid_v = sel;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if ((rdy & sel) == sel) begin
        if (sel[0]) q_a.push_back(ea);
        if (sel[1]) q_b.push_back(eb);
        if (sel[2]) q_c.push_back(ec);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid_v = '0;
    if (!done) begin
      n_total++;
      $display("FAIL issue_timeout: word %h not accepted within 100 cycles", word);
    end
  endtask

  task automatic idle(input int n);
    in_valid_v = '0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_out_valid[%0d]", tag, i), 64'(ov[i]), 64'd0);
      chk($sformatf("%s_imm[%0d]", tag, i), imm_v[i], 64'd0);
      chk($sformatf("%s_type[%0d]", tag, i), 64'(typ_v[i]), 64'd0);
      chk($sformatf("%s_flags[%0d]", tag, i), 64'({comp_v[i], ill_v[i]}), 64'd0);
      chk($sformatf("%s_in_ready[%0d]", tag, i), 64'(rdy[i]), 64'd1);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    exp_t z;
    z          = mk(64'd0, 3'd0, 1'b0, 1'b0);
    rst        = 1'b1;
    flush      = 1'b0;
    out_ready  = 1'b0;
    ir         = '0;
    in_valid_v = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset("rst");
    @(posedge clk);
    #1;

    // Shared vectors on all three configurations
    out_ready = 1'b1;
    issue(3'b111, 32'hFFF00093, mk(64'hFFFFFFFF, 3'd0, 1'b0, 1'b0),
          mk(64'hFFFFFFFF, 3'd0, 1'b0, 1'b0), mk(64'hFFFFFFFFFFFFFFFF, 3'd0, 1'b0, 1'b0));
    issue(3'b111, 32'hFE000EE3, mk(64'hFFFFFFFC, 3'd2, 1'b0, 1'b0),
          mk(64'hFFFFFFFC, 3'd2, 1'b0, 1'b0), mk(64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0, 1'b0));
    issue(3'b111, 32'hDEAD4432, mk(64'h0000000C, 3'd5, 1'b1, 1'b0),
          mk(64'hFFFFFDEA, 3'd0, 1'b0, 1'b0), mk(64'h000000000000000C, 3'd5, 1'b1, 1'b0));
    issue(3'b111, 32'h0000BFFD, mk(64'hFFFFFFFE, 3'd5, 1'b1, 1'b0),
          mk(64'h00000000, 3'd0, 1'b0, 1'b0), mk(64'hFFFFFFFFFFFFFFFE, 3'd5, 1'b1, 1'b0));
    issue(3'b111, 32'h00000000, mk(64'h0, 3'd5, 1'b1, 1'b1),
          mk(64'h0, 3'd0, 1'b0, 1'b0), mk(64'h0, 3'd5, 1'b1, 1'b1));
    issue(3'b111, 32'h800000B7, mk(64'h80000000, 3'd3, 1'b0, 1'b0),
          mk(64'h80000000, 3'd3, 1'b0, 1'b0), mk(64'hFFFFFFFF80000000, 3'd3, 1'b0, 1'b0));
    issue(3'b111, 32'h00007085, mk(64'hFFFE1000, 3'd5, 1'b1, 1'b0),
          mk(64'h00000000, 3'd0, 1'b0, 1'b0), mk(64'hFFFFFFFFFFFE1000, 3'd5, 1'b1, 1'b0));

    // Remaining 32-bit formats on the two RV32 instances
    issue(3'b011, 32'hFE112C23, mk(64'hFFFFFFF8, 3'd1, 1'b0, 1'b0),
          mk(64'hFFFFFFF8, 3'd1, 1'b0, 1'b0), z);
    issue(3'b011, 32'h0010006F, mk(64'h00000800, 3'd4, 1'b0, 1'b0),
          mk(64'h00000800, 3'd4, 1'b0, 1'b0), z);
    issue(3'b011, 32'h00001017, mk(64'h00001000, 3'd3, 1'b0, 1'b0),
          mk(64'h00001000, 3'd3, 1'b0, 1'b0), z);
    issue(3'b011, 32'h80008067, mk(64'hFFFFF800, 3'd0, 1'b0, 1'b0),
          mk(64'hFFFFF800, 3'd0, 1'b0, 1'b0), z);

    // Compressed layouts on the RVC instances
    issue(3'b101, 32'h00000040, mk(64'h4, 3'd5, 1'b1, 1'b0), z, mk(64'h4, 3'd5, 1'b1, 1'b0));
    issue(3'b101, 32'h00000004, mk(64'h0, 3'd5, 1'b1, 1'b1), z, mk(64'h0, 3'd5, 1'b1, 1'b1));
    issue(3'b101, 32'h00007101, mk(64'hFFFFFE00, 3'd5, 1'b1, 1'b0), z,
          mk(64'hFFFFFFFFFFFFFE00, 3'd5, 1'b1, 1'b0));
    issue(3'b101, 32'h0000D061, mk(64'hFFFFFFC0, 3'd5, 1'b1, 1'b0), z,
          mk(64'hFFFFFFFFFFFFFFC0, 3'd5, 1'b1, 1'b0));
    issue(3'b101, 32'h0000907D, mk(64'h3F, 3'd5, 1'b1, 1'b0), z, mk(64'h3F, 3'd5, 1'b1, 1'b0));
    issue(3'b101, 32'h0000987D, mk(64'hFFFFFFFF, 3'd5, 1'b1, 1'b0), z,
          mk(64'hFFFFFFFFFFFFFFFF, 3'd5, 1'b1, 1'b0));
    issue(3'b101, 32'h00009C7D, mk(64'h0, 3'd5, 1'b1, 1'b0), z, mk(64'h0, 3'd5, 1'b1, 1'b0));
    issue(3'b101, 32'h0000DC60, mk(64'h7C, 3'd5, 1'b1, 1'b0), z, mk(64'h7C, 3'd5, 1'b1, 1'b0));
    issue(3'b101, 32'h0000D582, mk(64'hE8, 3'd5, 1'b1, 1'b0), z, mk(64'hE8, 3'd5, 1'b1, 1'b0));
    issue(3'b101, 32'h00008000, mk(64'h0, 3'd5, 1'b1, 1'b0), z, mk(64'h0, 3'd5, 1'b1, 1'b0));
    issue(3'b101, 32'h000010FD, mk(64'hFFFFFFFF, 3'd5, 1'b1, 1'b0), z,
          mk(64'hFFFFFFFFFFFFFFFF, 3'd5, 1'b1, 1'b0));
    issue(3'b101, 32'h00001086, mk(64'h21, 3'd5, 1'b1, 1'b0), z, mk(64'h21, 3'd5, 1'b1, 1'b0));
    idle(3);

    // Backpressure: A held while B waits, then pop and accept on the same edge
    out_ready = 1'b0;
    issue(3'b001, 32'hFFF00093, mk(64'hFFFFFFFF, 3'd0, 1'b0, 1'b0), z, z);
    ir         = 32'hFE000EE3;
    in_valid_v = 3'b001;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(rdy[0]), 64'd0);
      chk("bp_hold_valid", 64'(ov[0]), 64'd1);
      chk("bp_hold_imm", imm_v[0], 64'hFFFFFFFF);
      chk("bp_hold_type", 64'(typ_v[0]), 64'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", 64'(rdy[0]), 64'd1);
    q_a.push_back(mk(64'hFFFFFFFC, 3'd2, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    idle(3);

    // Flush while an input is offered: the offered word must not appear
    issue(3'b001, 32'h0000BFFD, mk(64'hFFFFFFFE, 3'd5, 1'b1, 1'b0), z, z);
    ir         = 32'h00000040;
    in_valid_v = 3'b001;
    flush      = 1'b1;
    @(posedge clk);
    #1;
    flush      = 1'b0;
    in_valid_v = '0;
    @(negedge clk);
    chk("flush_drop_valid", 64'(ov[0]), 64'd0);
    @(posedge clk);
    #1;

    // Flush kills a held output
    out_ready = 1'b0;
    issue(3'b001, 32'h00007101, mk(64'hFFFFFE00, 3'd5, 1'b1, 1'b0), z, z);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    q_a.delete();
    @(negedge clk);
    chk("flush_kill_valid", 64'(ov[0]), 64'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue(3'b001, 32'h00000040, mk(64'h4, 3'd5, 1'b1, 1'b0), z, z);
    idle(3);

    // Reset mid-stream with flush and in_valid also asserted
    out_ready = 1'b0;
    issue(3'b101, 32'h0000BFFD, mk(64'hFFFFFFFE, 3'd5, 1'b1, 1'b0), z,
          mk(64'hFFFFFFFFFFFFFFFE, 3'd5, 1'b1, 1'b0));
    rst        = 1'b1;
    flush      = 1'b1;
    ir         = 32'h00000040;
    in_valid_v = 3'b111;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    flush      = 1'b0;
    in_valid_v = '0;
    q_a.delete();
    q_b.delete();
    q_c.delete();
    @(negedge clk);
    chk_reset("midrst");
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue(3'b111, 32'h800000B7, mk(64'h80000000, 3'd3, 1'b0, 1'b0),
          mk(64'h80000000, 3'd3, 1'b0, 1'b0), mk(64'hFFFFFFFF80000000, 3'd3, 1'b0, 1'b0));
    idle(4);

    chk("drained_a", 64'(q_a.size()), 64'd0);
    chk("drained_b", 64'(q_b.size()), 64'd0);
    chk("drained_c", 64'(q_c.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
